// File: rtl/minisrc_control_seq.sv
// minisrc_control_seq
// Hardwired control sequencer for the Mini SRC datapath. A Start pulse in
// IDLE runs one instruction: fetch (T0-T2), decode IR[31:27], execute
// (T3-T6), then a one-cycle DONE (or ERR for an illegal opcode) before
// returning to IDLE.
//
// Ports:
//   Clock, Clear         rising-edge clock, asynchronous active-high reset
//   Start                begin one instruction (sampled only in IDLE)
//   Step                 single-step advance (only with MINISRC_SINGLE_STEP_EN)
//   IR[31:0]             datapath IR register output
//   Busy, Done, Err      status: not-IDLE, completion pulse, illegal pulse
//   PCout..Rout          bus drive enables (at most one high)
//   Gra, Grb, Grc        register field selects (at most one high)
//   MARin..Read          register load and memory strobes
//   ALUop[NALU-1:0]      one-hot ALU select (0 AND .. 12 NOT)
//
// Configuration macro: MINISRC_SINGLE_STEP_EN adds the Step input; states
// T0-T6 then advance only on edges where Step is high.
module minisrc_control_seq #(
  parameter int OPW  = 5,
  parameter int NALU = 13
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Start,
`ifdef MINISRC_SINGLE_STEP_EN
  input  logic            Step,
`endif
  input  logic [31:0]     IR,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            Rout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            LOin,
  output logic            HIin,
  output logic            Rin,
  output logic            IncPC,
  output logic            Read,
  output logic [NALU-1:0] ALUop
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    C_ILL, C_THREE, C_MULDIV, C_UNARY
  } cls_t;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            err;
    logic            pcOut;
    logic            zlowOut;
    logic            zhighOut;
    logic            mdrOut;
    logic            rOut;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            marIn;
    logic            zIn;
    logic            pcIn;
    logic            mdrIn;
    logic            irIn;
    logic            yIn;
    logic            loIn;
    logic            hiIn;
    logic            rIn;
    logic            incPc;
    logic            read;
    logic [NALU-1:0] aluOp;
  } ctrl_t;

  state_t          state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  cls_t            cls;
  logic [NALU-1:0] aluSel;
  logic [OPW-1:0]  opcode;
  logic            unusedIr;

  assign opcode   = IR[31 -: OPW];
  // Only the opcode field matters to the sequencer; register fields are
  // decoded by the datapath's select-and-encode logic.
  assign unusedIr = ^IR[31-OPW:0];

  // Opcode decode: instruction class plus the ALU select bit it uses.
  always_comb begin
    cls    = C_ILL;
    aluSel = '0;
    case (int'(opcode))
      3:  begin cls = C_THREE;  aluSel[2]  = 1'b1; end
      4:  begin cls = C_THREE;  aluSel[3]  = 1'b1; end
      5:  begin cls = C_THREE;  aluSel[0]  = 1'b1; end
      6:  begin cls = C_THREE;  aluSel[1]  = 1'b1; end
      7:  begin cls = C_THREE;  aluSel[9]  = 1'b1; end
      8:  begin cls = C_THREE;  aluSel[10] = 1'b1; end
      9:  begin cls = C_THREE;  aluSel[6]  = 1'b1; end
      10: begin cls = C_THREE;  aluSel[7]  = 1'b1; end
      11: begin cls = C_THREE;  aluSel[8]  = 1'b1; end
      15: begin cls = C_MULDIV; aluSel[5]  = 1'b1; end
      16: begin cls = C_MULDIV; aluSel[4]  = 1'b1; end
      17: begin cls = C_UNARY;  aluSel[11] = 1'b1; end
      18: begin cls = C_UNARY;  aluSel[12] = 1'b1; end
      default: begin cls = C_ILL; aluSel = '0; end
    endcase
  end

  // Next state. If IR turns illegal after fetch the sequence aborts to ERR,
  // which never asserts any write strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = (cls == C_ILL) ? S_ERR : S_T3;
      S_T3:   state_d = (cls == C_ILL) ? S_ERR : S_T4;
      S_T4: begin
        case (cls)
          C_UNARY: state_d = S_DONE;
          C_ILL:   state_d = S_ERR;
          default: state_d = S_T5;
        endcase
      end
      S_T5: begin
        case (cls)
          C_THREE:  state_d = S_DONE;
          C_MULDIV: state_d = S_T6;
          default:  state_d = S_ERR;
        endcase
      end
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MINISRC_SINGLE_STEP_EN
    if (!Step && (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6}))
      state_d = state_q;
`endif
  end

  // Strobes for the state being entered, so the registered outputs line up
  // with the registered state and never glitch between edges.
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_T0: begin
        ctrl_d.pcOut = 1'b1; ctrl_d.marIn = 1'b1;
        ctrl_d.incPc = 1'b1; ctrl_d.zIn   = 1'b1;
      end
      S_T1: begin
        ctrl_d.zlowOut = 1'b1; ctrl_d.pcIn  = 1'b1;
        ctrl_d.read    = 1'b1; ctrl_d.mdrIn = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdrOut = 1'b1; ctrl_d.irIn = 1'b1;
      end
      S_T3: begin
        ctrl_d.rOut = 1'b1;
        case (cls)
          C_THREE:  begin ctrl_d.grb = 1'b1; ctrl_d.yIn = 1'b1; end
          C_MULDIV: begin ctrl_d.gra = 1'b1; ctrl_d.yIn = 1'b1; end
          C_UNARY:  begin ctrl_d.grb = 1'b1; ctrl_d.aluOp = aluSel; ctrl_d.zIn = 1'b1; end
          default:  ctrl_d.rOut = 1'b0;
        endcase
      end
      S_T4: begin
        case (cls)
          C_THREE: begin
            ctrl_d.grc = 1'b1; ctrl_d.rOut = 1'b1;
            ctrl_d.aluOp = aluSel; ctrl_d.zIn = 1'b1;
          end
          C_MULDIV: begin
            ctrl_d.grb = 1'b1; ctrl_d.rOut = 1'b1;
            ctrl_d.aluOp = aluSel; ctrl_d.zIn = 1'b1;
          end
          C_UNARY: begin
            ctrl_d.zlowOut = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.rIn = 1'b1;
          end
          default: ctrl_d.zIn = 1'b0;
        endcase
      end
      S_T5: begin
        case (cls)
          C_THREE:  begin ctrl_d.zlowOut = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.rIn = 1'b1; end
          C_MULDIV: begin ctrl_d.zlowOut = 1'b1; ctrl_d.loIn = 1'b1; end
          default:  ctrl_d.rIn = 1'b0;
        endcase
      end
      S_T6: begin
        ctrl_d.zhighOut = 1'b1; ctrl_d.hiIn = 1'b1;
      end
      S_DONE:  ctrl_d.done = 1'b1;
      S_ERR:   ctrl_d.err  = 1'b1;
      default: ctrl_d.busy = 1'b0;
    endcase
  end

  // State and registered strobes; Clear forces everything low at once.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign Busy     = ctrl_q.busy;
  assign Done     = ctrl_q.done;
  assign Err      = ctrl_q.err;
  assign PCout    = ctrl_q.pcOut;
  assign Zlowout  = ctrl_q.zlowOut;
  assign Zhighout = ctrl_q.zhighOut;
  assign MDRout   = ctrl_q.mdrOut;
  assign Rout     = ctrl_q.rOut;
  assign Gra      = ctrl_q.gra;
  assign Grb      = ctrl_q.grb;
  assign Grc      = ctrl_q.grc;
  assign MARin    = ctrl_q.marIn;
  assign Zin      = ctrl_q.zIn;
  assign PCin     = ctrl_q.pcIn;
  assign MDRin    = ctrl_q.mdrIn;
  assign IRin     = ctrl_q.irIn;
  assign Yin      = ctrl_q.yIn;
  assign LOin     = ctrl_q.loIn;
  assign HIin     = ctrl_q.hiIn;
  assign Rin      = ctrl_q.rIn;
  assign IncPC    = ctrl_q.incPc;
  assign Read     = ctrl_q.read;
  assign ALUop    = ctrl_q.aluOp;

endmodule

// File: tb/tb_minisrc_control_seq.sv
// Testbench for minisrc_control_seq. Expected strobe vectors for every cycle
// of an instruction are queued when Start is driven and popped one per
// cycle as the sequencer runs. A negedge monitor checks the bus, field
// select and ALU select one-hot-or-zero invariants on every cycle.
module tb_minisrc_control_seq;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        pcOut;
    logic        zlowOut;
    logic        zhighOut;
    logic        mdrOut;
    logic        rOut;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        marIn;
    logic        zIn;
    logic        pcIn;
    logic        mdrIn;
    logic        irIn;
    logic        yIn;
    logic        loIn;
    logic        hiIn;
    logic        rIn;
    logic        incPc;
    logic        read;
    logic [12:0] aluOp;
  } tbCtrl_t;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        Start = 1'b0;
  logic        Step  = 1'b1;
  logic [31:0] IR    = '0;
  logic        Busy, Done, Err, PCout, Zlowout, Zhighout, MDRout, Rout;
  logic        Gra, Grb, Grc, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        LOin, HIin, Rin, IncPC, Read;
  logic [12:0] ALUop;

  int total = 0;
  int bad   = 0;
  tbCtrl_t expQ[$];

  minisrc_control_seq #(.OPW(5), .NALU(13)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start),
`ifdef MINISRC_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IR(IR), .Busy(Busy), .Done(Done), .Err(Err),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .LOin(LOin),
    .HIin(HIin), .Rin(Rin), .IncPC(IncPC), .Read(Read), .ALUop(ALUop)
  );

  always #5 Clock = ~Clock;

  // 0 illegal, 1 three-operand, 2 MUL/DIV, 3 NEG/NOT
  function automatic int classOf(input logic [4:0] opc);
    if (opc >= 5'd3 && opc <= 5'd11) return 1;
    if (opc == 5'd15 || opc == 5'd16) return 2;
    if (opc == 5'd17 || opc == 5'd18) return 3;
    return 0;
  endfunction

  function automatic logic [12:0] aluOf(input logic [4:0] opc);
    case (opc)
      5'd5:  return 13'h0001;
      5'd6:  return 13'h0002;
      5'd3:  return 13'h0004;
      5'd4:  return 13'h0008;
      5'd16: return 13'h0010;
      5'd15: return 13'h0020;
      5'd9:  return 13'h0040;
      5'd10: return 13'h0080;
      5'd11: return 13'h0100;
      5'd7:  return 13'h0200;
      5'd8:  return 13'h0400;
      5'd17: return 13'h0800;
      5'd18: return 13'h1000;
      default: return 13'h0000;
    endcase
  endfunction

  // Cycles from T0 through the first IDLE cycle after DONE/ERR.
  function automatic int lenOf(input logic [4:0] opc);
    case (classOf(opc))
      1: return 8;
      2: return 9;
      3: return 7;
      default: return 5;
    endcase
  endfunction

  // Expected strobes in cycle k+cyc after Start sampled at edge k.
  function automatic tbCtrl_t expVec(input logic [4:0] opc, input int cyc);
    tbCtrl_t v;
    int      cls;
    int      e;
    v    = '0;
    cls  = classOf(opc);
    e    = cyc - 3;
    v.busy = 1'b1;
    if (cyc == 1) begin
      v.pcOut = 1; v.marIn = 1; v.incPc = 1; v.zIn = 1;
    end else if (cyc == 2) begin
      v.zlowOut = 1; v.pcIn = 1; v.read = 1; v.mdrIn = 1;
    end else if (cyc == 3) begin
      v.mdrOut = 1; v.irIn = 1;
    end else if (cls == 0) begin
      if (e == 1) v.err = 1; else v.busy = 0;
    end else if (cls == 1) begin
      case (e)
        1: begin v.grb = 1; v.rOut = 1; v.yIn = 1; end
        2: begin v.grc = 1; v.rOut = 1; v.aluOp = aluOf(opc); v.zIn = 1; end
        3: begin v.zlowOut = 1; v.gra = 1; v.rIn = 1; end
        4: v.done = 1;
        default: v.busy = 0;
      endcase
    end else if (cls == 2) begin
      case (e)
        1: begin v.gra = 1; v.rOut = 1; v.yIn = 1; end
        2: begin v.grb = 1; v.rOut = 1; v.aluOp = aluOf(opc); v.zIn = 1; end
        3: begin v.zlowOut = 1; v.loIn = 1; end
        4: begin v.zhighOut = 1; v.hiIn = 1; end
        5: v.done = 1;
        default: v.busy = 0;
      endcase
    end else begin
      case (e)
        1: begin v.grb = 1; v.rOut = 1; v.aluOp = aluOf(opc); v.zIn = 1; end
        2: begin v.zlowOut = 1; v.gra = 1; v.rIn = 1; end
        3: v.done = 1;
        default: v.busy = 0;
      endcase
    end
    return v;
  endfunction

  function automatic tbCtrl_t sampleDut();
    tbCtrl_t v;
    v = '{busy: Busy, done: Done, err: Err, pcOut: PCout, zlowOut: Zlowout,
          zhighOut: Zhighout, mdrOut: MDRout, rOut: Rout, gra: Gra, grb: Grb,
          grc: Grc, marIn: MARin, zIn: Zin, pcIn: PCin, mdrIn: MDRin,
          irIn: IRin, yIn: Yin, loIn: LOin, hiIn: HIin, rIn: Rin,
          incPc: IncPC, read: Read, aluOp: ALUop};
    return v;
  endfunction

  task automatic pushInstr(input logic [31:0] ir);
    for (int c = 1; c <= lenOf(ir[31:27]); c++)
      expQ.push_back(expVec(ir[31:27], c));
  endtask

  task automatic checkOutput(input string tag);
    tbCtrl_t exp, obs;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s scoreboard empty", tag);
    end else begin
      exp = expQ.pop_front();
      obs = sampleDut();
      assert (obs === exp) else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic checkZero(input string tag);
    tbCtrl_t obs;
    obs = sampleDut();
    total++;
    assert (obs === '0) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=0", tag, obs);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input string tag);
    int guard;
    pushInstr(ir);
    IR    = ir;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    checkOutput(tag);
    guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      @(posedge Clock); #1;
      checkOutput(tag);
      guard++;
    end
  endtask

  // Start held high across a whole instruction: the second instruction must
  // begin only after the DONE+IDLE round trip.
  task automatic applyHeld(input logic [31:0] ir, input string tag);
    int n;
    n = lenOf(ir[31:27]);
    pushInstr(ir);
    pushInstr(ir);
    IR    = ir;
    Start = 1'b1;
    for (int i = 1; i <= 2 * n; i++) begin
      @(posedge Clock); #1;
      if (i == n + 1) Start = 1'b0;
      checkOutput(tag);
    end
  endtask

  // Invariants on every cycle.
  always @(negedge Clock) begin
    total += 3;
    assert ($onehot0({PCout, Zlowout, Zhighout, MDRout, Rout})) else begin
      bad++;
      $error("[TB] FAIL busOnehot observed=%b expected=onehot0",
             {PCout, Zlowout, Zhighout, MDRout, Rout});
    end
    assert ($onehot0({Gra, Grb, Grc})) else begin
      bad++;
      $error("[TB] FAIL grOnehot observed=%b expected=onehot0", {Gra, Grb, Grc});
    end
    assert ($onehot0(ALUop)) else begin
      bad++;
      $error("[TB] FAIL aluOnehot observed=%h expected=onehot0", ALUop);
    end
  end

  initial begin
    logic [4:0] sweep [13];
    sweep = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
              5'd15, 5'd16, 5'd17, 5'd18};

    // Reset state
    Clear = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    checkZero("reset");
    Clear = 1'b0;
    @(posedge Clock); #1;
    checkZero("idleNoStart");

    applyStimulus(32'h2A2B8000, "and");
    applyStimulus(32'h81300000, "mul");
    applyStimulus(32'h92800000, "not");
    applyStimulus(32'hF8000000, "illegal31");
    applyStimulus(32'h60000000, "illegal12");

    // Clear while in T4 of ADD
    pushInstr(32'h1A2B8000);
    IR    = 32'h1A2B8000;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    checkOutput("addPreClear");
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      checkOutput("addPreClear");
    end
    expQ.delete();
    #2 Clear = 1'b1;
    #1 checkZero("clearImmediate");
    @(posedge Clock); #1;
    checkZero("clearHeld");
    Clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checkZero("noDoneAfterClear");
    end
    applyStimulus(32'h1A2B8000, "addAfterClear");

    applyHeld(32'h2A2B8000, "startHeld");

    // Full opcode sweep with random register fields
    for (int i = 0; i < 13; i++)
      applyStimulus({sweep[i], 27'($urandom)}, "sweep");

`ifdef MINISRC_SINGLE_STEP_EN
    // Step low for 5 cycles while in T4 of ADD
    for (int c = 1; c <= 5; c++) expQ.push_back(expVec(5'd3, c));
    IR    = 32'h1A2B8000;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    checkOutput("stepRun");
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      checkOutput("stepRun");
    end
    Step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(expVec(5'd3, 5));
      @(posedge Clock); #1;
      checkOutput("stepHoldT4");
    end
    Step = 1'b1;
    for (int c = 6; c <= 8; c++) expQ.push_back(expVec(5'd3, c));
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checkOutput("stepResume");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
